seq_det_param: RTL
==================

// Module: seq_det_param
// PURPOSE
//  Parametrised, runtime-programmable serial bit-sequence detector; successor to the fixed 4-bit "0110" Moore detector.
//  Pattern (up to PAT_W bits), length and overlap/non-overlap mode are programmable; input is valid-qualified.
//  Moore-style registered match pulse plus optional saturating match counter; sits on serial decode/framing paths.
// PARAMETERS
//  PAT_W        8           max pattern length in bits (>=2)
//  LEN_W        $clog2(PAT_W+1)  width of length fields (localparam-derived)
//  DEF_PATTERN  8'b0000_0110  pattern loaded at reset (LSB-aligned)
//  DEF_LEN      4           length loaded at reset
//  DEF_OVR      1'b1        mode at reset: 1 = overlapping, 0 = non-overlapping
//  CNT_W        16          match counter width (MATCH_CNT_EN only)
// PORTS
//  clk       in   1      clock, all logic on posedge
//  rst       in   1      synchronous, active-high reset
//  x         in   1      serial data bit
//  x_valid   in   1      x sampled only when 1
//  cfg_wr    in   1      load cfg_pattern/cfg_len/cfg_ovr
//  cfg_pattern in PAT_W  pattern; first bit received = bit [len-1], last = bit [0]
//  cfg_len   in   LEN_W  pattern length, legal 1..PAT_W
//  cfg_ovr   in   1      overlap mode
//  cnt_clr   in   1      clear match counter
//  z         out  1      match pulse (Moore, from state)
//  cfg_err   out  1      active config has illegal length
//  match_cnt out  CNT_W  saturating match count
// BEHAVIOUR
//  Reset: pattern/len/ovr <= DEF_*; history <= 0; fill <= 0; state <= ST_FILL; z=0, cfg_err=0, match_cnt=0.
//  History: on x_valid, hist <= {hist[PAT_W-2:0], x}; fill <= min(fill+1, len).
//  Hit = x_valid & (fill_next >= len) & (hist_next[len-1:0] == pattern[len-1:0]); bits above len ignored.
//  States: ST_FILL (fill<len), ST_HUNT (armed, no match), ST_MATCH (z=1).
//   ST_FILL/ST_HUNT/ST_MATCH: on hit -> ST_MATCH; on x_valid & !hit -> ST_HUNT if fill_next>=len else ST_FILL.
//   ST_MATCH & !x_valid -> ST_HUNT (ovr=1) or ST_FILL (ovr=0).
//  Non-overlap: on hit, fill <= 0 (history re-fills from scratch); overlap keeps history.
//  Latency: z high exactly the cycle after the completing x_valid sample; back-to-back hits keep z high.
//  x_valid=0: history, fill frozen; gaps do not break a partial match.
//  cfg_wr: new config active next cycle; hist<=0, fill<=0, state<=ST_FILL, z<=0. cfg_wr wins over same-cycle x_valid (sample dropped).
//  cfg_len==0 or >PAT_W: cfg_err=1, hit forced 0, state stays ST_FILL until legal cfg_wr or rst.
//  rst mid-operation: full return to reset values in the next cycle; in-flight match discarded.
// CONFIGURATION
//  MATCH_CNT_EN defined: match_cnt increments on each cycle entering ST_MATCH via hit, saturates at all-ones;
//   cnt_clr zeroes it and wins over a same-cycle increment; cfg_wr does not clear it.
//  MATCH_CNT_EN undefined: counter logic absent, match_cnt tied to 0, cnt_clr ignored.
// STRUCTURE
//  Package seq_det_pkg: state enum (ST_FILL, ST_HUNT, ST_MATCH), state-width localparam, length-legality function.
//  Sub-module seq_det_hist: shift register, fill counter, masked compare -> hit. Top holds config regs, FSM, counter.
// TESTING
//  1 Defaults (0110, len 4, ovr): x=0,1,1,0,1,1,0 every cycle -> z=1 after 4th and 7th bits only; match_cnt=2.
//  2 cfg 2'b11 len 2: ovr=1, x=1,1,1,1 -> z after bits 2,3,4 (3 hits); ovr=0 -> after bits 2,4 (2 hits).
//  3 Defaults, x_valid gaps of 3 idle cycles between bits of 0110 -> single z one cycle after last valid bit.
//  4 cfg_wr same cycle as completing bit of 0110 -> no z, state ST_FILL, new pattern matched from scratch.
//  5 cfg_len=0 then len=9 (PAT_W=8) -> cfg_err=1, no z on any stream; legal cfg_wr clears cfg_err.
//  6 CNT_W=2, 5 hits -> match_cnt 1,2,3,3,3; cnt_clr with hit -> 0; rst during ST_MATCH -> z=0 next cycle.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised serial sequence detector.
package seq_det_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_FILL  = 2'd0,
    ST_HUNT  = 2'd1,
    ST_MATCH = 2'd2
  } state_t;

  // A length is usable only if it selects at least one bit and fits in the pattern
  function automatic logic len_legal(input int unsigned len, input int unsigned pat_w);
    return (len != 0) && (len <= pat_w);
  endfunction

endpackage

// File: rtl/seq_det_hist.sv
// History shift register, fill counter and masked pattern compare for seq_det_param.
module seq_det_hist
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             x,
  input  logic             x_valid,
  input  logic             legal,
  input  logic             ovr,
  input  logic [LEN_W-1:0] len,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit,
  output logic             armed
);

  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] hist_nx;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] fill;
  logic [LEN_W-1:0] fill_nx;
  logic [LEN_W:0]   fill_inc;

  // Next history/fill as they would be after accepting x, and the masked compare on that view
  always_comb begin
    hist_nx  = {hist[PAT_W-2:0], x};
    fill_inc = {1'b0, fill} + (LEN_W+1)'(1);
    fill_nx  = (fill_inc >= {1'b0, len}) ? len : fill_inc[LEN_W-1:0];
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len));
    end
    armed = (fill_nx >= len);
    hit   = x_valid & legal & armed & (((hist_nx ^ pattern) & mask) == '0);
  end

  // Shift in valid bits; a reconfiguration wipes history and drops the same-cycle sample
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hist <= '0;
      fill <= '0;
    end else if (x_valid) begin
      hist <= hist_nx;
      fill <= (hit && !ovr) ? '0 : fill_nx;
    end
  end

endmodule

// File: rtl/seq_det_param.sv
// Programmable serial bit-sequence detector with Moore match output.
// Optional saturating match counter is built when MATCH_CNT_EN is defined.
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int                PAT_W       = 8,
  localparam int               LEN_W       = $clog2(PAT_W + 1),
  parameter logic [PAT_W-1:0]  DEF_PATTERN = PAT_W'(6),
  parameter logic [LEN_W-1:0]  DEF_LEN     = LEN_W'(4),
  parameter logic              DEF_OVR     = 1'b1,
  parameter int                CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             x_valid,
  input  logic             cfg_wr,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_ovr,
  input  logic             cnt_clr,
  output logic             z,
  output logic             cfg_err,
  output logic [CNT_W-1:0] match_cnt
);

  state_t           state;
  state_t           state_nx;
  logic [PAT_W-1:0] pattern_r;
  logic [LEN_W-1:0] len_r;
  logic             ovr_r;
  logic             legal;
  logic             hit;
  logic             hit_ok;
  logic             armed;

  assign legal   = len_legal(32'(len_r), PAT_W);
  assign cfg_err = ~legal;
  assign hit_ok  = hit & ~cfg_wr;
  assign z       = (state == ST_MATCH);

  seq_det_hist #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_hist (
    .clk     (clk),
    .rst     (rst),
    .clr     (cfg_wr),
    .x       (x),
    .x_valid (x_valid),
    .legal   (legal),
    .ovr     (ovr_r),
    .len     (len_r),
    .pattern (pattern_r),
    .hit     (hit),
    .armed   (armed)
  );

  // Active configuration: defaults at reset, replaced wholesale on cfg_wr
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_r <= DEF_PATTERN;
      len_r     <= DEF_LEN;
      ovr_r     <= DEF_OVR;
    end else if (cfg_wr) begin
      pattern_r <= cfg_pattern;
      len_r     <= cfg_len;
      ovr_r     <= cfg_ovr;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FILL;
    end else begin
      state <= state_nx;
    end
  end

  // Next state: reconfiguration or an illegal length pins the FSM in ST_FILL
  always_comb begin
    state_nx = state;
    if (cfg_wr || !legal) begin
      state_nx = ST_FILL;
    end else if (hit_ok) begin
      state_nx = ST_MATCH;
    end else if (x_valid) begin
      state_nx = armed ? ST_HUNT : ST_FILL;
    end else if (state == ST_MATCH) begin
      state_nx = ovr_r ? ST_HUNT : ST_FILL;
    end
  end

`ifdef MATCH_CNT_EN
  // Saturating count of hits; clear beats a same-cycle increment, cfg_wr leaves it alone
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      match_cnt <= '0;
    end else if (hit_ok && (match_cnt != '1)) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule
